// File: rtl/tone_dds_source.sv
// tone_dds_source: phase-continuous DDS sine source with quarter-wave LUT; define DITHER_EN for LFSR phase dither on lookup
module tone_dds_source #(
  parameter int PHASE_W    = 16,
  parameter int LUT_ADDR_W = 6,
  parameter int AMP_W      = 8,
  parameter int SAMPLE_DIV = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [PHASE_W-1:0]      tune_word,
  input  logic                    tune_valid,
  output logic                    tune_ready,
  input  logic [1:0]              amp_shift,
  output logic signed [AMP_W-1:0] sample_out,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun
);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int N  = 2 ** LUT_ADDR_W;
  // quarter-wave table, round(127*sin(pi/2*(i+0.5)/64)), sized for the default LUT_ADDR_W/AMP_W
  localparam logic [AMP_W-2:0] LUT [N] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };
  logic [DW-1:0]           div_q, div_d;
  logic [PHASE_W-1:0]      phase_q, phase_d, word_q, word_d, pend_q, pend_d, look;
  logic                    pend_v_q, pend_v_d, v0_q, v0_d, v1_q, v1_d, neg_q, neg_d;
  logic [AMP_W-2:0]        lut_q, lut_d;
  logic signed [AMP_W-1:0] out_q, out_d, mag, fold;
  logic                    valid_q, valid_d, ovr_q, ovr_d;
  logic                    tick, capture, land;
  logic [1:0]              quad;
  logic [LUT_ADDR_W-1:0]   idx;
`ifdef DITHER_EN
  localparam int D = PHASE_W - 2 - LUT_ADDR_W;
  logic [15:0] lfsr_q, lfsr_d;
  // dither LFSR steps once per sample tick
  always_comb lfsr_d = tick ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
  // LFSR state register
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr_q <= 16'hACE1;
    else lfsr_q <= lfsr_d;
  assign look = phase_q + PHASE_W'(lfsr_q[D-1:0]);
`else
  assign look = phase_q;
`endif
  assign tick       = en && (div_q == DW'(SAMPLE_DIV - 1));
  assign quad       = look[PHASE_W-1 -: 2];
  assign idx        = look[PHASE_W-3 -: LUT_ADDR_W];
  assign mag        = {1'b0, lut_q};
  assign fold       = neg_q ? -mag : mag;
  assign tune_ready = !pend_v_q;
  assign sample_out   = out_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  // divider, tune hand-off, phase step, lookup pipeline and output handshake
  always_comb begin
    capture  = tune_valid && !pend_v_q;
    land     = en && v1_q;
    div_d    = (en && !tick) ? div_q + 1'b1 : '0;
    word_d   = (tick && pend_v_q) ? pend_q : word_q;
    phase_d  = tick ? phase_q + word_d : phase_q;
    pend_d   = capture ? tune_word : pend_q;
    pend_v_d = capture || (pend_v_q && !tick);
    v0_d     = tick;
    v1_d     = en && v0_q;
    lut_d    = LUT[quad[0] ? ~idx : idx];
    neg_d    = quad[1];
    out_d    = land ? fold >>> amp_shift : out_q;
    valid_d  = en && (land || (valid_q && !sample_ready));
    ovr_d    = en && (ovr_q || (land && valid_q && !sample_ready));
  end
  // state registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_q    <= '0;
      phase_q  <= '0;
      word_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      lut_q    <= '0;
      neg_q    <= 1'b0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      phase_q  <= phase_d;
      word_q   <= word_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      lut_q    <= lut_d;
      neg_q    <= neg_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
endmodule

// File: tb/tb_tone_dds_source.sv
// tb_tone_dds_source: scoreboard bench for the DDS tone source
module tb_tone_dds_source;
  logic clk = 0, rst = 1, en = 0, tune_valid = 0, sample_ready = 0;
  logic [15:0] tune_word = '0;
  logic [1:0] amp_shift = '0;
  logic signed [7:0] sample_out;
  logic tune_ready, sample_valid, overrun;
  int vectors = 0, miscompares = 0, cyc = 0, en_cyc = 0, en_epoch = 0;
  int exp_q[$];

  tone_dds_source dut (
    .clk(clk), .rst(rst), .en(en), .tune_word(tune_word), .tune_valid(tune_valid),
    .tune_ready(tune_ready), .amp_shift(amp_shift), .sample_out(sample_out),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(logic [15:0] w);
    tune_word = w;
    tune_valid = 1;
    step(1);
    tune_valid = 0;
  endtask

  task automatic go();
    en = 1;
    en_cyc = cyc;
    en_epoch++;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d samples outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // monitor: compare every accepted sample and its timing against the scoreboard
  initial begin : mon
    int seen = 0, last = 0, e;
    forever begin
      @(negedge clk);
      if (!rst && sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_sample: got %0d, expected no sample", sample_out);
        end else begin
          e = exp_q.pop_front();
          chk("sample", int'(sample_out), e);
          if (seen != en_epoch) begin
            chk("first_latency", cyc - en_cyc, 66);
            seen = en_epoch;
          end else chk("spacing", cyc - last, 64);
          last = cyc;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    step(3);
    chk("rst_out", int'(sample_out), 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ready", tune_ready, 1);
    chk("rst_ovr", overrun, 0);
    rst = 0;
    step(100);
    chk("idle_out", int'(sample_out), 0);
    chk("idle_valid", sample_valid, 0);
    chk("idle_ready", tune_ready, 1);
    chk("idle_ovr", overrun, 0);
    sample_ready = 1;
    load(16'h4000);
    chk("pend_ready", tune_ready, 0);
    exp_q = '{127, -2, -127, 2, 127, -2, -127, 2};
    go();
    drain(700);
    chk("ready_after_tick", tune_ready, 1);
    amp_shift = 1;
    exp_q = '{63, -1, -64, 1};
    drain(400);
    amp_shift = 0;
    load(16'h8000);
    step(30);
    chk("retune_ready", tune_ready, 0);
    exp_q = '{-2, 2, -2, 2};
    drain(400);
    chk("retune_ready_back", tune_ready, 1);
    sample_ready = 0;
    step(100);
    chk("hold_valid", sample_valid, 1);
    chk("hold_ovr", overrun, 0);
    chk("hold_out", int'(sample_out), -2);
    step(40);
    chk("ovr_set", overrun, 1);
    chk("ovr_out", int'(sample_out), 2);
    chk("ovr_valid", sample_valid, 1);
    step(64);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_latest", int'(sample_out), -2);
    en = 0;
    step(1);
    chk("en_off_valid", sample_valid, 0);
    chk("en_off_ovr", overrun, 0);
    sample_ready = 1;
    go();
    load(16'h1234);
    step(29);
    chk("mid_pend", tune_ready, 0);
    rst = 1;
    #1;
    chk("mid_rst_out", int'(sample_out), 0);
    chk("mid_rst_valid", sample_valid, 0);
    chk("mid_rst_ready", tune_ready, 1);
    chk("mid_rst_ovr", overrun, 0);
    en = 0;
    step(2);
    rst = 0;
    step(1);
    exp_q = '{127, -2};
    load(16'h4000);
    go();
    drain(300);
    en = 0;
    rst = 1;
    step(1);
    rst = 0;
    exp_q = '{5, 8, 11};
    load(16'h0100);
    go();
    drain(400);
    en = 0;
    step(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
